// File: rtl/decrypt_iter_if.sv
// decrypt_iter_if: block handshake bundle for the AES-128
// decryption core (ciphertext/key in, plaintext out).
interface decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  modport master (
    output in_valid,
    output in,
    output key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  in,
    input  key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out
  );
endinterface

// File: rtl/decrypt_iter.sv
// decrypt_iter: iterative AES-128 decryption, one inverse
// round per clock, key walked backwards from K10 on the fly.
module decrypt_iter (
  input  logic      clk,
  input  logic      rst_n,
  decrypt_iter_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    LAST,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [127:0] s;
  logic [127:0] k;
  logic [127:0] o;
  logic [3:0]   rc;

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^
           (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse, 0 maps to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] a,
    input int         n
  );
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl8(x, 1) ^
           rotl8(x, 2) ^ rotl8(x, 3) ^
           rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(
    input logic [7:0] a
  );
    logic [7:0] y;
    y = rotl8(a, 1) ^ rotl8(a, 3) ^
        rotl8(a, 6) ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix(
    input logic [31:0] w
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    r0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^
         gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    r1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^
         gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    r2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^
         gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    r3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^
         gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    return {r0, r1, r2, r3};
  endfunction

  function automatic logic [7:0] rcon_of(
    input logic [3:0] i
  );
    logic [7:0] r;
    unique case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] add;
  logic [127:0] imc;

  // state path: InvShiftRows, InvSubBytes, key add, InvMixColumns
  always_comb begin
    isr = '0;
    isb = '0;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    for (int n = 0; n < 16; n++) begin
      isb[127-8*n -: 8] =
        isbox(isr[127-8*n -: 8]);
    end
    add = isb ^ k;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] =
        inv_mix(add[127-32*c -: 32]);
    end
  end

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  kw_in;
  logic [31:0]  kw_sub;
  logic [31:0]  rcw;
  logic [31:0]  e0, e1, e2, e3;
  logic [127:0] k_exp;
  logic [127:0] k_inv;
  logic [3:0]   rsel;

  // key path: one SubWord shared by forward and inverse steps
  always_comb begin
    w0     = k[127:96];
    w1     = k[95:64];
    w2     = k[63:32];
    w3     = k[31:0];
    rsel   = (state == INIT) ? 4'd9 : rc;
    rcw    = {rcon_of(rsel), 24'h0};
    kw_in  = (state == KEYEXP) ? w3 : (w3 ^ w2);
    kw_sub = sub_word({kw_in[23:0], kw_in[31:24]});
    e0     = w0 ^ kw_sub ^ rcw;
    e1     = w1 ^ e0;
    e2     = w2 ^ e1;
    e3     = w3 ^ e2;
    k_exp  = {e0, e1, e2, e3};
    k_inv  = {w0 ^ kw_sub ^ rcw,
              w1 ^ w0,
              w2 ^ w1,
              w3 ^ w2};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (io.in_valid) state_nx = KEYEXP;
      KEYEXP: if (rc == 4'd9)  state_nx = INIT;
      INIT:   state_nx = ROUND;
      ROUND:  if (rc == 4'd0)  state_nx = LAST;
      LAST:   state_nx = DONE;
      DONE:   if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath registers: block state, round key, counter, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= '0;
      k  <= '0;
      o  <= '0;
      rc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            s  <= io.in;
            k  <= io.key;
            rc <= 4'd0;
          end
        end
        KEYEXP: begin
          k  <= k_exp;
          rc <= rc + 4'd1;
        end
        INIT: begin
          s  <= s ^ k;
          k  <= k_inv;
          rc <= 4'd8;
        end
        ROUND: begin
          s  <= imc;
          k  <= k_inv;
          rc <= rc - 4'd1;
        end
        LAST: begin
          s <= add;
          o <= add;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.out       = o;

endmodule

// File: tb/tb_decrypt_iter.sv
// tb_decrypt_iter: directed FIPS-197 vectors, handshake timing,
// reset abort and round-trip against a forward AES model.
module tb_decrypt_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decrypt_iter_if io();

  decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int cmp = 0;
  int bad = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] C1_K  =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C  =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_P  =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C   =
    128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_P   =
    128'h3243f6a8885a308d313198a2e0370734;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^
          {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(
    input logic [127:0] pt,
    input logic [127:0] kk
  );
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   b [16];
    logic [7:0]   c [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]],
             sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++)
      b[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) c[n] = sb[b[n]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          b[row+4*col] = c[row+4*((col+row)%4)];
      if (rnd < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = b[4*col];
          a1 = b[4*col+1];
          a2 = b[4*col+2];
          a3 = b[4*col+3];
          b[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          b[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          b[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          b[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++)
        b[n] = b[n] ^ w[4*rnd+n/4][31-8*(n%4) -: 8];
    end
    r = '0;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = b[n];
    return r;
  endfunction

  task automatic send(input logic [127:0] c,
                      input logic [127:0] kk);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in       = c;
    io.key      = kk;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (io.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    cmp++;
    if (io.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", io.in_ready);
    end
    cmp++;
    if (io.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", io.out_valid);
    end
    cmp++;
    if (io.out !== 128'h0) begin
      bad++;
      $display("FAIL reset_out: got %h want 0", io.out);
    end
  endtask

  task automatic test_vector(input string nm,
                             input logic [127:0] c,
                             input logic [127:0] kk,
                             input logic [127:0] p);
    int n;
    io.out_ready = 1'b1;
    send(c, kk);
    wait_out(n);
    cmp++;
    if (n !== 21) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 21", nm, n);
    end
    cmp++;
    if (io.out !== p) begin
      bad++;
      $display("FAIL %s_out: got %h want %h", nm, io.out, p);
    end
    @(posedge clk);
    #1;
    cmp++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_one_clock: got valid=%b ready=%b want 0 1",
               nm, io.out_valid, io.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    io.out_ready = 1'b0;
    send(C1_C, C1_K);
    wait_out(n);
    cmp++;
    if (n !== 21) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 21", n);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      cmp++;
      if (io.out !== C1_P || io.out_valid !== 1'b1 ||
          io.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got out=%h v=%b r=%b want %h 1 0",
                 i, io.out, io.out_valid, io.in_ready, C1_P);
      end
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    cmp++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got r=%b v=%b want 1 0",
               io.in_ready, io.out_valid);
    end
  endtask

  task automatic test_busy_input();
    int n;
    bit rdy_bad;
    io.out_ready = 1'b1;
    send(C1_C, C1_K);
    n = 0;
    rdy_bad = 1'b0;
    while (io.out_valid !== 1'b1 && n < 100) begin
      if (io.in_ready !== 1'b0) rdy_bad = 1'b1;
      io.in_valid = 1'($urandom_range(0, 1));
      io.in  = {$urandom, $urandom, $urandom, $urandom};
      io.key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      n++;
    end
    io.in_valid = 1'b0;
    cmp++;
    if (rdy_bad) begin
      bad++;
      $display("FAIL busy_in_ready: got 1 want 0 while busy");
    end
    cmp++;
    if (n !== 21) begin
      bad++;
      $display("FAIL busy_latency: got %0d want 21", n);
    end
    cmp++;
    if (io.out !== C1_P) begin
      bad++;
      $display("FAIL busy_out: got %h want %h", io.out, C1_P);
    end
    @(posedge clk);
    #1;
    cmp++;
    if (io.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_idle: got %b want 1", io.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    io.out_ready = 1'b1;
    send(B_C, B_K);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    io.in_valid = 1'b1;
    io.in  = B_C;
    io.key = B_K;
    #1;
    cmp++;
    if (io.out !== 128'h0 || io.out_valid !== 1'b0 ||
        io.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_abort: got out=%h v=%b r=%b want 0 0 1",
               io.out, io.out_valid, io.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    cmp++;
    if (io.in_ready !== 1'b1 || io.out !== 128'h0) begin
      bad++;
      $display("FAIL rstmid_ignored: got r=%b out=%h want 1 0",
               io.in_ready, io.out);
    end
    send(C1_C, C1_K);
    wait_out(n);
    cmp++;
    if (n !== 21) begin
      bad++;
      $display("FAIL rstmid_latency: got %0d want 21", n);
    end
    cmp++;
    if (io.out !== C1_P) begin
      bad++;
      $display("FAIL rstmid_out: got %h want %h", io.out, C1_P);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cnt;
    int n;
    logic [127:0] got_a;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in  = C1_C;
    io.key = C1_K;
    @(posedge clk);
    #1;
    io.in  = B_C;
    io.key = B_K;
    cnt = 0;
    got_a = '0;
    while (io.in_ready !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (io.out_valid === 1'b1) got_a = io.out;
    end
    @(posedge clk);
    #1;
    cnt++;
    io.in_valid = 1'b0;
    cmp++;
    if (cnt !== 23) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d want 23", cnt);
    end
    cmp++;
    if (io.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept2: got %b want 0", io.in_ready);
    end
    cmp++;
    if (got_a !== C1_P) begin
      bad++;
      $display("FAIL b2b_out1: got %h want %h", got_a, C1_P);
    end
    wait_out(n);
    cmp++;
    if (n !== 21 || io.out !== B_P) begin
      bad++;
      $display("FAIL b2b_out2: got %h after %0d want %h after 21",
               io.out, n, B_P);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_roundtrip();
    int n;
    logic [127:0] p, kk, c;
    io.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p  = {$urandom, $urandom, $urandom, $urandom};
      kk = {$urandom, $urandom, $urandom, $urandom};
      c  = enc(p, kk);
      send(c, kk);
      wait_out(n);
      cmp++;
      if (io.out !== p) begin
        bad++;
        $display("FAIL roundtrip[%0d]: got %h want %h", i, io.out, p);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.in        = '0;
    io.key       = '0;
    build_sbox();
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_vector("c1", C1_C, C1_K, C1_P);
    test_vector("appb", B_C, B_K, B_P);
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    test_back_to_back();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
